// File: rtl/instruction_unit_pkg.sv
// rtl/instruction_unit_pkg.sv - shared encodings and helpers for the instruction unit
package instruction_unit_pkg;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PCSEL_INC = 2'b00;
    localparam pc_sel_t PCSEL_BR  = 2'b01;
    localparam pc_sel_t PCSEL_JMP = 2'b10;
    localparam pc_sel_t PCSEL_REG = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/instruction_unit_if.sv
// rtl/instruction_unit_if.sv - instruction memory req/ack fetch bus
interface instruction_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instruction_unit_pc_next_mux.sv
// rtl/instruction_unit_pc_next_mux.sv - combinational next-PC selector
module instruction_unit_pc_next_mux
    import instruction_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] ir_i,
    input  logic [31:0] reg_in_i,
    input  pc_sel_t     pc_sel_i,
    output logic [31:0] pc_next_o
);

    logic [31:0] imm;

    assign imm = sign_ext16(ir_i[15:0]);

    // pc_i already points past the current instruction, so offsets are relative to it
    always_comb begin
        pc_next_o = pc_i + WORD_BYTES;
        case (pc_sel_i)
            PCSEL_INC: pc_next_o = pc_i + WORD_BYTES;
            PCSEL_BR:  pc_next_o = pc_i + {imm[29:0], 2'b00};
            PCSEL_JMP: pc_next_o = {pc_i[31:28], ir_i, 2'b00};
            PCSEL_REG: pc_next_o = reg_in_i;
        endcase
    end

endmodule

// File: rtl/instruction_unit.sv
// rtl/instruction_unit.sv - PC/IR owner with req/ack instruction fetch
module instruction_unit
    import instruction_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req_i,
    input  logic               pc_ld_i,
    input  pc_sel_t            pc_sel_i,
    input  logic [31:0]        reg_in_i,
    instruction_unit_if.master imem,
    output logic [31:0]        pc_out_o,
    output logic [31:0]        ir_out_o,
    output logic [31:0]        se16_o,
    output logic               fetch_done_o,
    output logic               busy_o,
    output logic               addr_err_o,
    output logic               time_err_o,
    output logic               seq_err_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        addr_err_q, addr_err_d;
    logic        time_err_q, time_err_d;
    logic        seq_err_q, seq_err_d;
    logic [31:0] pc_next;

    instruction_unit_pc_next_mux u_pc_next_mux (
        .pc_i      (pc_q),
        .ir_i      (ir_q[25:0]),
        .reg_in_i  (reg_in_i),
        .pc_sel_i  (pc_sel_i),
        .pc_next_o (pc_next)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        addr_d     = addr_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        addr_err_d = addr_err_q;
        time_err_d = time_err_q;
        seq_err_d  = seq_err_q;
        case (state_q)
            ST_IDLE: begin
                // Fetch address is the pre-load PC; a simultaneous pc_ld still updates PC
                if (pc_ld_i) pc_d = pc_next;
                if (fetch_req_i) begin
                    if (pc_q[1:0] != 2'b00) begin
                        addr_err_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        cnt_d   = 8'd0;
                    end
                end
            end
            ST_WAIT: begin
                if (fetch_req_i || pc_ld_i) seq_err_d = 1'b1;
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    pc_d    = pc_q + WORD_BYTES;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    req_d      = 1'b0;
                    time_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'd0;
            addr_q     <= 32'd0;
            req_q      <= 1'b0;
            cnt_q      <= 8'd0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            time_err_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            addr_err_q <= addr_err_d;
            time_err_q <= time_err_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign pc_out_o       = pc_q;
    assign ir_out_o       = ir_q;
    assign se16_o         = sign_ext16(ir_q[15:0]);
    assign fetch_done_o   = done_q;
    assign busy_o         = (state_q == ST_WAIT);
    assign addr_err_o     = addr_err_q;
    assign time_err_o     = time_err_q;
    assign seq_err_o      = seq_err_q;

endmodule

// File: tb/tb_instruction_unit.sv
// tb/tb_instruction_unit.sv - self-checking bench for instruction_unit
module tb_instruction_unit;

    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic        pc_ld = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] reg_in = 32'd0;
    logic [31:0] pc_out, ir_out, se16;
    logic        fetch_done, busy, addr_err, time_err, seq_err;

    instruction_unit_if imem ();

    instruction_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req_i  (fetch_req),
        .pc_ld_i      (pc_ld),
        .pc_sel_i     (pc_sel),
        .reg_in_i     (reg_in),
        .imem         (imem),
        .pc_out_o     (pc_out),
        .ir_out_o     (ir_out),
        .se16_o       (se16),
        .fetch_done_o (fetch_done),
        .busy_o       (busy),
        .addr_err_o   (addr_err),
        .time_err_o   (time_err),
        .seq_err_o    (seq_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural PC/IR plus an "outstanding fetch" record
    logic [31:0] m_pc = RESET_PC, m_ir = 32'd0, m_addr = 32'd0, old_pc;
    logic        m_fetching = 1'b0, m_done = 1'b0;
    logic        m_aerr = 1'b0, m_terr = 1'b0, m_serr = 1'b0;
    int          m_wait_cycles = 0;

    function automatic logic [31:0] model_next(input logic [1:0] sel, input logic [31:0] pc,
                                               input logic [31:0] ir, input logic [31:0] rin);
        int off;
        case (sel)
            2'd0:    return pc + 32'd4;
            2'd1: begin
                off = int'($signed(ir[15:0]));
                return pc + 32'(off * 4);
            end
            2'd2:    return (pc & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
            default: return rin;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = RESET_PC; m_ir = 32'd0; m_addr = 32'd0;
            m_fetching = 1'b0; m_done = 1'b0; m_wait_cycles = 0;
            m_aerr = 1'b0; m_terr = 1'b0; m_serr = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_fetching) begin
                if (fetch_req || pc_ld) m_serr = 1'b1;
                m_wait_cycles++;
                if (imem.imem_ack) begin
                    m_ir = imem.imem_rdata;
                    m_pc = m_pc + 32'd4;
                    m_fetching = 1'b0;
                    m_done = 1'b1;
                end else if (m_wait_cycles >= TIMEOUT) begin
                    m_fetching = 1'b0;
                    m_terr = 1'b1;
                end
            end else begin
                old_pc = m_pc;
                if (pc_ld) m_pc = model_next(pc_sel, old_pc, m_ir, reg_in);
                if (fetch_req) begin
                    if (old_pc % 4 != 0) m_aerr = 1'b1;
                    else begin
                        m_fetching = 1'b1;
                        m_addr = old_pc;
                        m_wait_cycles = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("pc", pc_out, m_pc);
        chk("ir", ir_out, m_ir);
        chk("se16", se16, 32'(int'($signed(m_ir[15:0]))));
        chk("req", {31'd0, imem.imem_req}, {31'd0, m_fetching});
        chk("addr", imem.imem_addr, m_addr);
        chk("busy", {31'd0, busy}, {31'd0, m_fetching});
        chk("done", {31'd0, fetch_done}, {31'd0, m_done});
        chk("addr_err", {31'd0, addr_err}, {31'd0, m_aerr});
        chk("time_err", {31'd0, time_err}, {31'd0, m_terr});
        chk("seq_err", {31'd0, seq_err}, {31'd0, m_serr});
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_sel = 2'b11; reg_in = v; pc_ld = 1'b1;
        cyc();
        pc_ld = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] data, input int delay);
        fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0;
        repeat (delay) cyc();
        imem.imem_ack = 1'b1; imem.imem_rdata = data;
        cyc();
        imem.imem_ack = 1'b0;
    endtask

    int ack_pct[6] = '{30, 0, 60, 10, 90, 5};
    int req_cnt;
    logic saw_done;

    initial begin
        imem.imem_ack = 1'b0;
        imem.imem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        chk("rst_pc", pc_out, RESET_PC);
        chk("rst_ir", ir_out, 32'd0);
        chk("rst_req", {31'd0, imem.imem_req}, 32'd0);

        // Basic fetch, ack three cycles into WAIT
        fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0;
        chk("t1_req", {31'd0, imem.imem_req}, 32'd1);
        chk("t1_addr", imem.imem_addr, 32'd0);
        repeat (2) cyc();
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'h2008_FFFF;
        cyc();
        imem.imem_ack = 1'b0;
        chk("t1_ir", ir_out, 32'h2008_FFFF);
        chk("t1_se16", se16, 32'hFFFF_FFFF);
        chk("t1_pc", pc_out, 32'd4);
        chk("t1_done", {31'd0, fetch_done}, 32'd1);
        cyc();
        chk("t1_done_pulse", {31'd0, fetch_done}, 32'd0);

        // Branch and jump targets
        fetch(32'h0000_FFFE, 1);
        chk("t2_pc8", pc_out, 32'd8);
        pc_sel = 2'b01; pc_ld = 1'b1;
        cyc();
        pc_ld = 1'b0;
        chk("t2_branch", pc_out, 32'd0);
        load_pc(32'hA000_0000);
        fetch(32'h0000_0010, 0);
        chk("t2_pc_a4", pc_out, 32'hA000_0004);
        pc_sel = 2'b10; pc_ld = 1'b1;
        cyc();
        pc_ld = 1'b0;
        chk("t2_jump", pc_out, 32'hA000_0040);

        // Misaligned fetch
        load_pc(32'h0000_0003);
        fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0;
        chk("t3_req", {31'd0, imem.imem_req}, 32'd0);
        chk("t3_addr_err", {31'd0, addr_err}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);

        // Timeout: no ack ever
        load_pc(32'h0000_0100);
        fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0;
        req_cnt = 0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem.imem_req) req_cnt++;
            if (fetch_done) saw_done = 1'b1;
            cyc();
        end
        chk("t4_req_cycles", 32'(req_cnt), 32'd16);
        chk("t4_time_err", {31'd0, time_err}, 32'd1);
        chk("t4_pc", pc_out, 32'h0000_0100);
        chk("t4_ir", ir_out, 32'h0000_0010);
        chk("t4_no_done", {31'd0, saw_done}, 32'd0);

        // PC wrap and pc_ld during WAIT
        load_pc(32'hFFFF_FFFC);
        fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0;
        pc_sel = 2'b11; reg_in = 32'h0000_0055; pc_ld = 1'b1;
        cyc();
        pc_ld = 1'b0;
        chk("t5_seq_err", {31'd0, seq_err}, 32'd1);
        chk("t5_pc_held", pc_out, 32'hFFFF_FFFC);
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'h0000_1234;
        cyc();
        imem.imem_ack = 1'b0;
        chk("t5_wrap", pc_out, 32'd0);

        // Reset mid-fetch, ack arriving around and after it
        fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0;
        cyc();
        reset = 1'b1;
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t6_async_req", {31'd0, imem.imem_req}, 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        imem.imem_ack = 1'b0;
        chk("t6_ir", ir_out, 32'd0);
        chk("t6_pc", pc_out, RESET_PC);
        chk("t6_done", {31'd0, fetch_done}, 32'd0);
        chk("t6_errs", {29'd0, addr_err, time_err, seq_err}, 32'd0);

        // Randomized traffic against the model
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 500; i++) begin
                fetch_req = (int'($urandom_range(0, 99)) < 30);
                pc_ld = (int'($urandom_range(0, 99)) < 25);
                pc_sel = 2'($urandom_range(0, 3));
                reg_in = $urandom();
                if ($urandom_range(0, 9) < 8) reg_in[1:0] = 2'b00;
                imem.imem_ack = (int'($urandom_range(0, 99)) < ack_pct[b]);
                imem.imem_rdata = $urandom();
                reset = ($urandom_range(0, 999) < 5);
                cyc();
            end
        end
        reset = 1'b0; fetch_req = 1'b0; pc_ld = 1'b0; imem.imem_ack = 1'b0;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
